gold_seq_gen_par: RTL

Parametrised NR Gold-sequence generator (TS 38.211 §5.2.1), c(n) = (x1(n+Nc) + x2(n+Nc)) mod 2. It produces W sequence bits per cycle on a valid/ready stream, with a runtime c_init, length and start offset. It serves PBCH DMRS, PBCH/PDSCH scrambling and any later consumer, replacing per-use serial generators. Downstream blocks consume words directly with no serial-to-parallel stage.

---
 rtl/gold_seq_gen_par.sv | 105 ++++++++++
 1 files changed

// File: rtl/gold_seq_gen_par.sv
// gold_seq_gen_par: W-bit-per-cycle NR Gold sequence generator with runtime seed, length and offset
module gold_seq_gen_par #(
  parameter int W = 8,
  parameter int LEN_W = 16,
  parameter int NC = 1600
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [30:0]              c_init,
  input  logic [LEN_W-1:0]         seq_len,
  input  logic [LEN_W-1:0]         skip,
  output logic                     busy,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(W+1)-1:0]   out_nbits,
  output logic                     done
);
  localparam int SW = $clog2(W+1);
  localparam int DW = LEN_W + 12;
  typedef enum logic [2:0] {IDLE, LOAD, DISCARD, RUN, DONE} state_t;
  state_t state, state_n;
  logic [30:0] x1, x2, cinit_r;
  logic [30:0] x1s [0:W];
  logic [30:0] x2s [0:W];
  logic [LEN_W-1:0] len_r, skip_r, r_q;
  logic [DW-1:0] d_q;
  logic [SW-1:0] d_step, r_step, adv;
  logic [W-1:0] word;
  logic hs, take;
  assign hs = out_valid && out_ready;
  assign take = (state == RUN) && (!out_valid || out_ready) && (r_q != '0);
  assign d_step = (d_q >= DW'(W)) ? SW'(W) : d_q[SW-1:0];
  assign r_step = (r_q >= LEN_W'(W)) ? SW'(W) : r_q[SW-1:0];
  assign adv = (state == DISCARD) ? d_step : take ? r_step : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    x1s[0] = x1;
    x2s[0] = x2;
    for (int k = 0; k < W; k++) begin
      x1s[k+1] = {x1s[k][3] ^ x1s[k][0], x1s[k][30:1]};
      x2s[k+1] = {x2s[k][3] ^ x2s[k][2] ^ x2s[k][1] ^ x2s[k][0], x2s[k][30:1]};
    end
    word = '0;
    for (int i = 0; i < W; i++) word[i] = (SW'(i) < r_step) ? x1s[i][0] ^ x2s[i][0] : 1'b0;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? LOAD : IDLE;
      LOAD:    state_n = (len_r == '0) ? DONE : DISCARD;
      DISCARD: state_n = (d_q == DW'(d_step)) ? RUN : DISCARD;
      RUN:     state_n = (hs && out_last) ? DONE : RUN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1 <= '0;
      x2 <= '0;
      cinit_r <= '0;
      len_r <= '0;
      skip_r <= '0;
      r_q <= '0;
      d_q <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_nbits <= '0;
    end else begin
      if (state == IDLE && start) begin
        cinit_r <= c_init;
        len_r <= seq_len;
        skip_r <= skip;
      end
      if (state == LOAD) begin
        x1 <= 31'h1;
        x2 <= cinit_r;
        d_q <= DW'(NC) + DW'(skip_r);
        r_q <= len_r;
      end else begin
        x1 <= x1s[adv];
        x2 <= x2s[adv];
      end
      if (state == DISCARD) d_q <= d_q - DW'(d_step);
      if (take) begin
        out_data <= word;
        out_nbits <= r_step;
        out_last <= r_q == LEN_W'(r_step);
        out_valid <= 1'b1;
        r_q <= r_q - LEN_W'(r_step);
      end else if (hs) begin
        out_valid <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end
endmodule
